// File: rtl/ddsm_input_skew_if.sv
// Interface bundling the control, data and status signals of ddsm_input_skew.
// Parameters:
//   P_SEG_W    bits per segment
//   P_SEG_NUM  number of segments
// Signals:
//   i_en       pipeline advance enable (0 = freeze)
//   i_flush    synchronous clear of all stages
//   i_vld      i_data carries a valid sample
//   i_data     input word, segment k = i_data[k*P_SEG_W +: P_SEG_W]
//   o_data     skewed output word
//   o_seg_vld  valid tag per output segment
//   o_primed   sticky flag, first valid sample reached the top segment
// Modports: master drives the inputs, slave is the skew stage itself.
interface ddsm_input_skew_if #(
  parameter int unsigned P_SEG_W   = 8,
  parameter int unsigned P_SEG_NUM = 3
);

  logic                         i_en;
  logic                         i_flush;
  logic                         i_vld;
  logic [P_SEG_NUM*P_SEG_W-1:0] i_data;
  logic [P_SEG_NUM*P_SEG_W-1:0] o_data;
  logic [P_SEG_NUM-1:0]         o_seg_vld;
  logic                         o_primed;

  modport master (
    output i_en,
    output i_flush,
    output i_vld,
    output i_data,
    input  o_data,
    input  o_seg_vld,
    input  o_primed
  );

  modport slave (
    input  i_en,
    input  i_flush,
    input  i_vld,
    input  i_data,
    output o_data,
    output o_seg_vld,
    output o_primed
  );

endinterface

// File: rtl/ddsm_input_skew.sv
// Input skew stage for a segmented (pipelined) DDSM accumulator.
// The input word is split into P_SEG_NUM segments of P_SEG_W bits; segment k
// is delayed by P_BASE_DELAY+k enabled cycles so that each accumulator segment
// receives its operand together with the carry from the segment below.
// Each segment chain carries a valid tag alongside the data.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    ddsm_input_skew_if.slave (i_en, i_flush, i_vld, i_data in;
//          o_data, o_seg_vld, o_primed out)
// Edge priority: i_rst > i_flush > i_en. All outputs are registered.
module ddsm_input_skew #(
  parameter int unsigned P_SEG_W      = 8,
  parameter int unsigned P_SEG_NUM    = 3,
  parameter int unsigned P_BASE_DELAY = 1
) (
  input logic                i_clk,
  input logic                i_rst,
  ddsm_input_skew_if.slave   bus
);

  localparam int unsigned TagW = P_SEG_W + 1;

  // Asserted on any edge that clears the whole pipeline.
  logic clear;
  assign clear = i_rst | bus.i_flush;

  logic primed_q;
  logic primed_d;

  for (genvar k = 0; k < int'(P_SEG_NUM); k++) begin : g_seg
    localparam int D = int'(P_BASE_DELAY) + k;

    // Element 0 is the chain input stage, element D-1 drives the output.
    logic [TagW-1:0] chain_q [D];
    logic [TagW-1:0] chain_in;

    assign chain_in = {bus.i_vld, bus.i_data[k*P_SEG_W +: P_SEG_W]};

    always_ff @(posedge i_clk) begin
      if (clear) begin
        for (int i = 0; i < D; i++) begin
          chain_q[i] <= '0;
        end
      end else if (bus.i_en) begin
        chain_q[0] <= chain_in;
        for (int i = 1; i < D; i++) begin
          chain_q[i] <= chain_q[i-1];
        end
      end
    end

    assign bus.o_data[k*P_SEG_W +: P_SEG_W] = chain_q[D-1][P_SEG_W-1:0];
    assign bus.o_seg_vld[k]                 = chain_q[D-1][P_SEG_W];

    if (k == int'(P_SEG_NUM) - 1) begin : g_top
      // Tag about to land in the top output register on the next enabled edge.
      logic tail_vld;
      if (D == 1) begin : g_direct
        assign tail_vld = chain_in[P_SEG_W];
      end else begin : g_chain
        assign tail_vld = chain_q[D-2][P_SEG_W];
      end

      always_comb begin
        primed_d = primed_q;
        if (bus.i_en) begin
          primed_d = primed_q | tail_vld;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (clear) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= primed_d;
    end
  end

  assign bus.o_primed = primed_q;

endmodule

// File: tb/tb_ddsm_input_skew.sv
module tb_ddsm_input_skew;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddsm_input_skew_if #(.P_SEG_W(8), .P_SEG_NUM(3)) bus_a ();
  ddsm_input_skew_if #(.P_SEG_W(4), .P_SEG_NUM(4)) bus_b ();

  ddsm_input_skew #(.P_SEG_W(8), .P_SEG_NUM(3), .P_BASE_DELAY(1)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  ddsm_input_skew #(.P_SEG_W(4), .P_SEG_NUM(4), .P_BASE_DELAY(2)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b)
  );

  typedef struct {
    logic [23:0] a_data;
    logic [2:0]  a_vld;
    logic        a_primed;
    logic [15:0] b_data;
    logic [3:0]  b_vld;
    logic        b_primed;
  } exp_t;

  exp_t        exp_q[$];
  logic [24:0] hist[$];   // accepted samples {vld, data}, oldest first, since last clear
  logic        prim_a = 1'b0;
  logic        prim_b = 1'b0;
  int          checks = 0;
  int          fails  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Entry presented dly enabled edges ago; empty history reads as zero.
  function automatic logic [24:0] tap(input int dly);
    if (hist.size() >= dly) return hist[hist.size() - dly];
    return '0;
  endfunction

  task automatic model_edge(input logic r, input logic f, input logic e, input logic v,
                            input logic [23:0] d, output exp_t x);
    logic [24:0] t;
    if (r || f) begin
      hist.delete();
    end else if (e) begin
      hist.push_back({v, d});
      if (hist.size() > 8) void'(hist.pop_front());
    end
    for (int k = 0; k < 3; k++) begin
      t = tap(1 + k);
      x.a_data[k*8 +: 8] = t[k*8 +: 8];
      x.a_vld[k] = t[24];
    end
    for (int k = 0; k < 4; k++) begin
      t = tap(2 + k);
      x.b_data[k*4 +: 4] = t[k*4 +: 4];
      x.b_vld[k] = t[24];
    end
    if (r || f) begin
      prim_a = 1'b0;
      prim_b = 1'b0;
    end else begin
      prim_a = prim_a | x.a_vld[2];
      prim_b = prim_b | x.b_vld[3];
    end
    x.a_primed = prim_a;
    x.b_primed = prim_b;
  endtask

  task automatic step(input logic r, input logic f, input logic e, input logic v,
                      input logic [23:0] d);
    exp_t x;
    #1;
    rst           = r;
    bus_a.i_flush = f;
    bus_a.i_en    = e;
    bus_a.i_vld   = v;
    bus_a.i_data  = d;
    bus_b.i_flush = f;
    bus_b.i_en    = e;
    bus_b.i_vld   = v;
    bus_b.i_data  = d[15:0];
    @(posedge clk);
    model_edge(r, f, e, v, d, x);
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor: one expected response per clock edge.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      cmp("a_data",   32'(bus_a.o_data),    32'(x.a_data));
      cmp("a_vld",    32'(bus_a.o_seg_vld), 32'(x.a_vld));
      cmp("a_primed", 32'(bus_a.o_primed),  32'(x.a_primed));
      cmp("b_data",   32'(bus_b.o_data),    32'(x.b_data));
      cmp("b_vld",    32'(bus_b.o_seg_vld), 32'(x.b_vld));
      cmp("b_primed", 32'(bus_b.o_primed),  32'(x.b_primed));
    end
  end

  initial begin
    // Reset state
    step(1, 0, 1, 0, 24'h0);
    @(negedge clk);
    cmp("rst_data", 32'(bus_a.o_data), 32'h0);
    cmp("rst_vld", 32'(bus_a.o_seg_vld), 32'h0);
    cmp("rst_primed", 32'(bus_a.o_primed), 32'h0);

    // Single sample walking up the segments
    step(0, 0, 1, 1, 24'h030201);
    @(negedge clk);
    cmp("t1_seg0", 32'(bus_a.o_data[7:0]), 32'h01);
    cmp("t1_vld0", 32'(bus_a.o_seg_vld), 32'b001);
    step(0, 0, 1, 0, 24'h0);
    @(negedge clk);
    cmp("t1_seg1", 32'(bus_a.o_data[15:8]), 32'h02);
    cmp("t1_vld1", 32'(bus_a.o_seg_vld), 32'b010);
    step(0, 0, 1, 0, 24'h0);
    @(negedge clk);
    cmp("t1_seg2", 32'(bus_a.o_data[23:16]), 32'h03);
    cmp("t1_vld2", 32'(bus_a.o_seg_vld), 32'b100);
    cmp("t1_primed", 32'(bus_a.o_primed), 32'h1);

    // Back-to-back stream: seg0 newest, seg2 oldest
    step(1, 0, 1, 0, 24'h0);
    step(0, 0, 1, 1, 24'h030201);
    step(0, 0, 1, 1, 24'h060504);
    step(0, 0, 1, 1, 24'h090807);
    @(negedge clk);
    cmp("t2_data", 32'(bus_a.o_data), 32'h030507);
    cmp("t2_vld", 32'(bus_a.o_seg_vld), 32'b111);

    // Stall after the first sample
    step(1, 0, 1, 0, 24'h0);
    step(0, 0, 1, 1, 24'h030201);
    step(0, 0, 0, 1, 24'hdeadbe);
    step(0, 0, 0, 1, 24'hbeefca);
    @(negedge clk);
    cmp("t3_hold_data", 32'(bus_a.o_data), 32'h000001);
    cmp("t3_hold_vld", 32'(bus_a.o_seg_vld), 32'b001);
    step(0, 0, 1, 1, 24'h060504);
    @(negedge clk);
    cmp("t3_resume_data", 32'(bus_a.o_data), 32'h000204);
    cmp("t3_resume_vld", 32'(bus_a.o_seg_vld), 32'b011);

    // Flush with enable low from a full pipeline
    step(0, 0, 1, 1, 24'h090807);
    step(0, 0, 1, 1, 24'h0c0b0a);
    @(negedge clk);
    cmp("t4_full_vld", 32'(bus_a.o_seg_vld), 32'b111);
    cmp("t4_full_primed", 32'(bus_a.o_primed), 32'h1);
    step(0, 1, 0, 1, 24'hffffff);
    @(negedge clk);
    cmp("t4_flush_data", 32'(bus_a.o_data), 32'h0);
    cmp("t4_flush_vld", 32'(bus_a.o_seg_vld), 32'h0);
    cmp("t4_flush_primed", 32'(bus_a.o_primed), 32'h0);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 1, 0, 24'h0);
      @(negedge clk);
      cmp("t4_discard_vld", 32'(bus_a.o_seg_vld), 32'h0);
    end

    // Reset colliding with flush and a valid sample mid-stream
    step(0, 0, 1, 1, 24'h123456);
    step(0, 0, 1, 1, 24'h789abc);
    step(1, 1, 1, 1, 24'haaaaaa);
    @(negedge clk);
    cmp("t5_rst_data", 32'(bus_a.o_data), 32'h0);
    cmp("t5_rst_vld", 32'(bus_a.o_seg_vld), 32'h0);
    step(0, 0, 1, 1, 24'h112233);
    step(0, 0, 1, 0, 24'h0);
    step(0, 0, 1, 0, 24'h0);
    @(negedge clk);
    cmp("t5_top_seg", 32'(bus_a.o_data[23:16]), 32'h11);
    cmp("t5_top_vld", 32'(bus_a.o_seg_vld), 32'b100);

    // Second configuration: 4 x 4-bit segments, base delay 2
    step(1, 0, 1, 0, 24'h0);
    step(0, 0, 1, 1, 24'h004321);
    for (int j = 1; j <= 5; j++) begin
      if (j > 1) step(0, 0, 1, 0, 24'h0);
      @(negedge clk);
      if (j >= 2) begin
        cmp("t6_seg", 32'(bus_b.o_data[4*(j-2) +: 4]), 32'(j - 1));
        cmp("t6_vld", 32'(bus_b.o_seg_vld), 32'(1 << (j - 2)));
      end
      cmp("t6_primed", 32'(bus_b.o_primed), 32'(j == 5));
    end

    // Randomised traffic checked by the scoreboard
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(63) == 0), ($urandom_range(31) == 0), ($urandom_range(3) != 0),
           ($urandom_range(3) != 0), 24'($urandom));
    end
    step(0, 0, 1, 0, 24'h0);
    @(negedge clk);
    @(negedge clk);
    cmp("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
